// File: rtl/neuron_mac3_if.sv
// Handshake and operand bus for the three-input neuron MAC.
// The master drives the request and the muxed operands; the neuron is the slave.
interface neuron_mac3_if;
  logic        start;
  logic [15:0] bias;
  logic [15:0] data_in;
  logic [15:0] weight_in;
  logic [1:0]  select;
  logic        busy;
  logic        done;
  logic [15:0] result;

  modport master (
    output start, bias, data_in, weight_in,
    input  select, busy, done, result
  );

  modport slave (
    input  start, bias, data_in, weight_in,
    output select, busy, done, result
  );
endinterface

// File: rtl/neuron_mac3.sv
// Three-input neuron: bias + sum of data*weight over the 3:1 mux,
// rescaled, saturated to 16 bits, optional ReLU, one result per start.
//
// state | meaning
// IDLE  | waiting for start; result held
// MAC   | one product per cycle, select 00 -> 01 -> 10
// OUT   | rescale/saturate/ReLU, register result, pulse done next cycle
module neuron_mac3 #(
  parameter int FRAC_BITS = 8,
  parameter bit RELU      = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  neuron_mac3_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t             state, state_nxt;
  logic [1:0]         sel, sel_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic [15:0]        res_q, res_nxt;
  logic signed [33:0] acc, acc_nxt;

  logic signed [31:0] prod;
  logic signed [33:0] prod_ext;
  logic signed [33:0] bias_ext;
  logic signed [33:0] scaled;
  logic [15:0]        sat;

  assign prod     = $signed(bus.data_in) * $signed(bus.weight_in);
  assign prod_ext = $signed({{2{prod[31]}}, prod});
  assign bias_ext = $signed({{18{bus.bias[15]}}, bus.bias}) <<< FRAC_BITS;
  // Arithmetic shift floors toward minus infinity, matching fixed-point truncation.
  assign scaled   = acc >>> FRAC_BITS;

  always_comb begin
    sat = scaled[15:0];
    if (scaled > 34'sd32767)
      sat = 16'h7FFF;
    else if (scaled < -34'sd32768)
      sat = 16'h8000;
    if (RELU && sat[15])
      sat = 16'h0000;
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    res_nxt   = res_q;
    acc_nxt   = acc;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt   = bias_ext;
          sel_nxt   = 2'd0;
          busy_nxt  = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        acc_nxt = acc + prod_ext;
        if (sel == 2'd2) begin
          sel_nxt   = 2'd0;
          state_nxt = OUT;
        end else begin
          sel_nxt = sel + 2'd1;
        end
      end
      OUT: begin
        res_nxt   = sat;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= 2'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= 16'h0000;
      acc    <= '0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      res_q  <= res_nxt;
      acc    <= acc_nxt;
    end
  end

  assign bus.select = sel;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;

endmodule

// File: tb/tb_neuron_mac3.sv
// Directed bench for neuron_mac3: one ReLU instance and one linear instance
// share stimulus; a behavioural 3:1 mux feeds operands by select.
module tb_neuron_mac3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bias;
  logic [15:0] d0, d1, d2, w0, w1, w2;

  int n_chk  = 0;
  int n_pass = 0;

  neuron_mac3_if ifa ();
  neuron_mac3_if ifl ();

  assign ifa.start     = start;
  assign ifa.bias      = bias;
  assign ifa.data_in   = (ifa.select == 2'd0) ? d0 : (ifa.select == 2'd1) ? d1 : d2;
  assign ifa.weight_in = (ifa.select == 2'd0) ? w0 : (ifa.select == 2'd1) ? w1 : w2;
  assign ifl.start     = start;
  assign ifl.bias      = bias;
  assign ifl.data_in   = (ifl.select == 2'd0) ? d0 : (ifl.select == 2'd1) ? d1 : d2;
  assign ifl.weight_in = (ifl.select == 2'd0) ? w0 : (ifl.select == 2'd1) ? w1 : w2;

  neuron_mac3 #(.FRAC_BITS(8), .RELU(1'b1)) u_relu (.clk(clk), .rst_n(rst_n), .bus(ifa));
  neuron_mac3 #(.FRAC_BITS(8), .RELU(1'b0)) u_lin  (.clk(clk), .rst_n(rst_n), .bus(ifl));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [15:0] a0, a1, a2, b0, b1, b2);
    d0 = a0; d1 = a1; d2 = a2;
    w0 = b0; w1 = b1; w2 = b2;
  endtask

  // Full transaction from cycle 0 (start high) to cycle 5 (done).
  task automatic run(input string tag, input logic [15:0] b,
                     input logic [15:0] exp_relu, input logic [15:0] exp_lin);
    bias  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_c1_busy"}, 32'(ifa.busy), 32'd1);
    chk({tag, "_c1_sel"},  32'(ifa.select), 32'd0);
    step();
    chk({tag, "_c2_sel"},  32'(ifa.select), 32'd1);
    step();
    chk({tag, "_c3_sel"},  32'(ifa.select), 32'd2);
    step();
    chk({tag, "_c4_sel"},  32'(ifa.select), 32'd0);
    chk({tag, "_c4_busy"}, 32'(ifa.busy), 32'd1);
    chk({tag, "_c4_done"}, 32'(ifa.done), 32'd0);
    step();
    chk({tag, "_c5_done"}, 32'(ifa.done), 32'd1);
    chk({tag, "_c5_busy"}, 32'(ifa.busy), 32'd0);
    chk({tag, "_relu"},    32'(ifa.result), 32'(exp_relu));
    chk({tag, "_lin"},     32'(ifl.result), 32'(exp_lin));
    step();
    chk({tag, "_c6_done"}, 32'(ifa.done), 32'd0);
    chk({tag, "_hold"},    32'(ifa.result), 32'(exp_relu));
  endtask

  initial begin
    int n_done;
    rst_n = 1'b0;
    start = 1'b0;
    bias  = 16'h0000;
    set_ops(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel",    32'(ifa.select), 32'd0);
    chk("rst_busy",   32'(ifa.busy), 32'd0);
    chk("rst_done",   32'(ifa.done), 32'd0);
    chk("rst_result", 32'(ifl.result), 32'h0000);
    rst_n = 1'b1;
    step();

    // 1.0*1.0 three times
    set_ops(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    run("unity", 16'h0000, 16'h0300, 16'h0300);

    // -2.0 + 3*0.5 = -0.5
    set_ops(16'h0080, 16'h0080, 16'h0080, 16'h0100, 16'h0100, 16'h0100);
    run("bias_relu", 16'hFE00, 16'h0000, 16'hFF80);

    // 1.5 + 1.0 + 1.0 - 3.0 = 0.5, distinct operand per select
    set_ops(16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0080, 16'hFF00);
    run("per_sel", 16'h0180, 16'h0080, 16'h0080);

    // three raw products of -1 -> -3/256 floors to -1 LSB
    set_ops(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 16'h0001);
    run("floor", 16'h0000, 16'h0000, 16'hFFFF);

    set_ops(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run("sat_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF);

    set_ops(16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run("sat_neg", 16'h7FFF, 16'h0000, 16'h8000);

    // starts at cycles 2 and 4 ignored; cycle 5 start accepted
    set_ops(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    bias  = 16'h0000;
    start = 1'b1;
    step();
    start = 1'b0;
    bias  = 16'h0100;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk("coll_c5_done",   32'(ifa.done), 32'd1);
    chk("coll_c5_result", 32'(ifa.result), 32'h0300);
    n_done = 0;
    for (int i = 6; i <= 9; i++) begin
      step();
      start = 1'b0;
      if (ifa.done) n_done++;
    end
    chk("coll_extra_done", 32'(n_done), 32'd0);
    step();
    chk("coll_c10_done",   32'(ifa.done), 32'd1);
    chk("coll_c10_result", 32'(ifl.result), 32'h0400);
    step();

    // asynchronous reset during the second MAC cycle
    bias  = 16'h0500;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mid_sel_pre", 32'(ifa.select), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_sel",    32'(ifa.select), 32'd0);
    chk("mid_busy",   32'(ifa.busy), 32'd0);
    chk("mid_done",   32'(ifa.done), 32'd0);
    chk("mid_result", 32'(ifl.result), 32'h0000);
    step();
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ifa.done) n_done++;
    end
    chk("mid_no_done", 32'(n_done), 32'd0);
    chk("mid_idle_busy", 32'(ifa.busy), 32'd0);

    set_ops(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    run("post_rst", 16'h0100, 16'h0400, 16'h0400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
